// File: rtl/seg7_scan_decoder_if.sv
// Bundle of the observed 7-segment scan bus and the decoded-frame handshake.
// master: the scan source and frame consumer; slave: the decoder.
interface seg7_scan_decoder_if #(
  parameter int DISP   = 8,
  parameter int DIGITS = 4
);
  logic [DISP-1:0]     seg_in;
  logic [DIGITS-1:0]   an_in;
  logic                frame_ready;
  logic                frame_valid;
  logic [4*DIGITS-1:0] frame_bcd;
  logic [DIGITS-1:0]   frame_dp;
  logic [DIGITS-1:0]   frame_err;
  logic                overrun;

  modport master (
    output seg_in, an_in, frame_ready,
    input  frame_valid, frame_bcd, frame_dp, frame_err, overrun
  );

  modport slave (
    input  seg_in, an_in, frame_ready,
    output frame_valid, frame_bcd, frame_dp, frame_err, overrun
  );
endinterface

// File: rtl/seg7_scan_decoder.sv
// Snoops a multiplexed active-low 7-segment bus, debounces each digit dwell,
// and assembles digits 0..DIGITS-1 into a BCD frame with valid/ready output.
module seg7_scan_decoder #(
  parameter int DISP   = 8,
  parameter int DIGITS = 4,
  parameter int STABLE = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  seg7_scan_decoder_if.slave bus
);

  localparam int IDXW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int CNTW = $clog2(STABLE + 1);
  localparam int SW   = DIGITS + DISP;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(DIGITS - 1);
  localparam logic [CNTW-1:0] CNT_MAX  = CNTW'(STABLE);
  localparam logic [CNTW-1:0] CNT_PRE  = CNTW'(STABLE - 1);

  typedef enum logic {SYNC, COLLECT} state_t;

  // Returns {err, bcd}; blank decodes to F without error.
  function automatic logic [4:0] decode_seg(input logic [6:0] s);
    case (s)
      7'h40:   decode_seg = 5'h00;
      7'h79:   decode_seg = 5'h01;
      7'h24:   decode_seg = 5'h02;
      7'h30:   decode_seg = 5'h03;
      7'h19:   decode_seg = 5'h04;
      7'h12:   decode_seg = 5'h05;
      7'h02:   decode_seg = 5'h06;
      7'h78:   decode_seg = 5'h07;
      7'h00:   decode_seg = 5'h08;
      7'h10:   decode_seg = 5'h09;
      7'h7F:   decode_seg = 5'h0F;
      default: decode_seg = 5'h1E;
    endcase
  endfunction

  logic [SW-1:0]       r_prev;
  logic [CNTW-1:0]     r_stab_cnt;
  state_t              r_state;
  logic [IDXW-1:0]     r_exp;
  logic [4*DIGITS-1:0] r_buf_bcd;
  logic [DIGITS-1:0]   r_buf_dp;
  logic [DIGITS-1:0]   r_buf_err;
  logic                r_valid;
  logic [4*DIGITS-1:0] r_bcd;
  logic [DIGITS-1:0]   r_dp;
  logic [DIGITS-1:0]   r_err;
  logic                r_overrun;

  logic [SW-1:0]       w_sample;
  logic                w_same;
  logic [DIGITS-1:0]   w_an_act;
  logic                w_onehot;
  logic [IDXW-1:0]     w_idx;
  logic                w_capture;
  logic [4:0]          w_dec;
  logic                w_dp;
  state_t              w_state_nxt;
  logic [IDXW-1:0]     w_exp_nxt;
  logic                w_store;
  logic                w_complete;
  logic                w_load;
  logic [4*DIGITS-1:0] w_frm_bcd;
  logic [DIGITS-1:0]   w_frm_dp;
  logic [DIGITS-1:0]   w_frm_err;

  assign w_sample = {bus.an_in, bus.seg_in};
  assign w_same   = (w_sample == r_prev);
  assign w_an_act = ~bus.an_in;
  assign w_onehot = (w_an_act != '0) && ((w_an_act & (w_an_act - DIGITS'(1))) == '0);
  assign w_dec    = decode_seg(bus.seg_in[6:0]);
  assign w_dp     = ~bus.seg_in[7];

  always_comb begin
    w_idx = '0;
    for (int unsigned i = DIGITS; i > 0; i--) begin
      if (w_an_act[i-1]) w_idx = IDXW'(i - 1);
    end
  end

  // Fires once per dwell: only the edge on which the count reaches STABLE.
  assign w_capture = w_same && (r_stab_cnt == CNT_PRE) && w_onehot;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_prev     <= '1;
      r_stab_cnt <= '0;
    end else begin
      r_prev <= w_sample;
      if (!w_same)                  r_stab_cnt <= '0;
      else if (r_stab_cnt != CNT_MAX) r_stab_cnt <= r_stab_cnt + CNTW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= SYNC;
      r_exp   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_exp   <= w_exp_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_exp_nxt   = r_exp;
    w_store     = 1'b0;
    w_complete  = 1'b0;
    if (w_capture) begin
      case (r_state)
        SYNC: begin
          if (w_idx == '0) begin
            w_store     = 1'b1;
            w_exp_nxt   = IDXW'(1);
            w_state_nxt = COLLECT;
          end
        end
        COLLECT: begin
          if (w_idx == r_exp) begin
            w_store = 1'b1;
            if (w_idx == LAST_IDX) begin
              w_complete  = 1'b1;
              w_exp_nxt   = '0;
              w_state_nxt = SYNC;
            end else begin
              w_exp_nxt = r_exp + IDXW'(1);
            end
          end else if (w_idx == '0) begin
            w_store   = 1'b1;
            w_exp_nxt = IDXW'(1);
          end else begin
            w_exp_nxt   = '0;
            w_state_nxt = SYNC;
          end
        end
        default: w_state_nxt = SYNC;
      endcase
    end
  end

  // Restarting at digit 0 overwrites stale buffer slots in order before completion.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_buf_bcd <= '0;
      r_buf_dp  <= '0;
      r_buf_err <= '0;
    end else if (w_store) begin
      r_buf_bcd[4*w_idx +: 4] <= w_dec[3:0];
      r_buf_dp[w_idx]         <= w_dp;
      r_buf_err[w_idx]        <= w_dec[4];
    end
  end

  // The last digit goes straight to the output so the frame loads on its capture edge.
  always_comb begin
    w_frm_bcd = r_buf_bcd;
    w_frm_dp  = r_buf_dp;
    w_frm_err = r_buf_err;
    w_frm_bcd[4*(DIGITS-1) +: 4] = w_dec[3:0];
    w_frm_dp[DIGITS-1]           = w_dp;
    w_frm_err[DIGITS-1]          = w_dec[4];
  end

  assign w_load = w_complete && (!r_valid || bus.frame_ready);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_valid   <= 1'b0;
      r_bcd     <= '0;
      r_dp      <= '0;
      r_err     <= '0;
      r_overrun <= 1'b0;
    end else begin
      if (w_load) begin
        r_valid <= 1'b1;
        r_bcd   <= w_frm_bcd;
        r_dp    <= w_frm_dp;
        r_err   <= w_frm_err;
      end else if (r_valid && bus.frame_ready) begin
        r_valid <= 1'b0;
      end
      if (w_complete && r_valid && !bus.frame_ready) r_overrun <= 1'b1;
    end
  end

  assign bus.frame_valid = r_valid;
  assign bus.frame_bcd   = r_bcd;
  assign bus.frame_dp    = r_dp;
  assign bus.frame_err   = r_err;
  assign bus.overrun     = r_overrun;

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Directed bench for seg7_scan_decoder: frames expected by the stimulus are
// queued and compared when the decoder hands them over.
module tb_seg7_scan_decoder;

  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_fail   = 0;
  logic [23:0] sb_q[$];  // {err, dp, bcd}

  seg7_scan_decoder_if #(.DISP(8), .DIGITS(4)) bus ();

  seg7_scan_decoder #(.DISP(8), .DIGITS(4), .STABLE(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic dwell(input logic [3:0] an, input logic [7:0] seg, input int n);
    bus.an_in  = an;
    bus.seg_in = seg;
    tick(n);
  endtask

  task automatic scan4(input logic [7:0] s0, input logic [7:0] s1,
                       input logic [7:0] s2, input logic [7:0] s3);
    dwell(4'hE, s0, 8);
    dwell(4'hD, s1, 8);
    dwell(4'hB, s2, 8);
    dwell(4'h7, s3, 8);
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 50 && sb_q.size() != 0; i++) tick(1);
    chk(tag, 32'(sb_q.size()), 32'd0);
  endtask

  always @(negedge clk) begin
    if (bus.frame_valid && bus.frame_ready) begin
      chk("frame_expected", 32'(sb_q.size() != 0), 32'd1);
      if (sb_q.size() != 0) begin
        logic [23:0] e;
        e = sb_q.pop_front();
        chk("frame_bcd", 32'(bus.frame_bcd), 32'(e[15:0]));
        chk("frame_dp_err", 32'({bus.frame_err, bus.frame_dp}), 32'({e[23:20], e[19:16]}));
      end
    end
  end

  initial begin
    rst_n           = 1'b0;
    bus.an_in       = 4'hF;
    bus.seg_in      = 8'hFF;
    bus.frame_ready = 1'b1;
    tick(3);
    rst_n = 1'b1;
    tick(1);
    chk("rst_valid", 32'(bus.frame_valid), 32'd0);
    chk("rst_bcd", 32'(bus.frame_bcd), 32'd0);
    chk("rst_dp", 32'(bus.frame_dp), 32'd0);
    chk("rst_err", 32'(bus.frame_err), 32'd0);
    chk("rst_overrun", 32'(bus.overrun), 32'd0);

    // Basic scan 0,1,2,3
    sb_q.push_back({4'b0000, 4'b0000, 16'h3210});
    scan4(8'hC0, 8'hF9, 8'hA4, 8'hB0);
    dwell(4'hF, 8'hFF, 4);
    drain("basic_drain");
    chk("basic_valid_low", 32'(bus.frame_valid), 32'd0);

    // Digit 1 dwell too short: digit 2 arrives out of order, no frame
    dwell(4'hE, 8'hC0, 8);
    dwell(4'hD, 8'hF9, 4);
    dwell(4'hB, 8'hA4, 8);
    dwell(4'h7, 8'hB0, 8);
    dwell(4'hF, 8'hFF, 4);
    chk("short_no_frame", 32'(bus.frame_valid), 32'd0);
    // Digits 1..3 alone must not complete a frame from SYNC
    dwell(4'hD, 8'hF9, 8);
    dwell(4'hB, 8'hA4, 8);
    dwell(4'h7, 8'hB0, 8);
    dwell(4'hF, 8'hFF, 4);
    chk("short_still_sync", 32'(bus.frame_valid), 32'd0);

    // Blank, unrecognised and DP patterns
    sb_q.push_back({4'b0100, 4'b0001, 16'h9EF0});
    scan4(8'h40, 8'hFF, 8'hD5, 8'h90);
    dwell(4'hF, 8'hFF, 4);
    drain("mixed_drain");

    // Backpressure: second frame dropped, first held
    bus.frame_ready = 1'b0;
    sb_q.push_back({4'b0000, 4'b0000, 16'h3210});
    scan4(8'hC0, 8'hF9, 8'hA4, 8'hB0);
    chk("bp_first_valid", 32'(bus.frame_valid), 32'd1);
    chk("bp_no_overrun_yet", 32'(bus.overrun), 32'd0);
    scan4(8'h99, 8'h92, 8'h82, 8'hF8);
    dwell(4'hF, 8'hFF, 2);
    chk("bp_held_valid", 32'(bus.frame_valid), 32'd1);
    chk("bp_held_frame", 32'({bus.frame_err, bus.frame_dp, bus.frame_bcd}), 32'h0003210);
    chk("bp_overrun", 32'(bus.overrun), 32'd1);
    bus.frame_ready = 1'b1;
    tick(1);
    chk("bp_valid_cleared", 32'(bus.frame_valid), 32'd0);
    chk("bp_queue_empty", 32'(sb_q.size()), 32'd0);
    chk("bp_overrun_sticky", 32'(bus.overrun), 32'd1);

    // Multi-hot digit enables never capture
    dwell(4'b0011, 8'hC0, 20);
    dwell(4'b1100, 8'hC0, 20);
    dwell(4'hD, 8'hF9, 8);
    dwell(4'hB, 8'hA4, 8);
    dwell(4'h7, 8'hB0, 8);
    dwell(4'hF, 8'hFF, 4);
    chk("multihot_no_frame", 32'(bus.frame_valid), 32'd0);

    // Reset mid-frame discards digits 0-1
    dwell(4'hE, 8'hC0, 8);
    dwell(4'hD, 8'hF9, 8);
    bus.an_in  = 4'hF;
    bus.seg_in = 8'hFF;
    rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1;
    chk("mid_rst_outputs", 32'({bus.frame_valid, bus.frame_err, bus.frame_dp, bus.frame_bcd}), 32'd0);
    chk("mid_rst_overrun", 32'(bus.overrun), 32'd0);
    dwell(4'hB, 8'hA4, 8);
    dwell(4'h7, 8'hB0, 8);
    chk("mid_rst_no_partial", 32'(bus.frame_valid), 32'd0);
    sb_q.push_back({4'b0000, 4'b0000, 16'h8765});
    scan4(8'h92, 8'h82, 8'hF8, 8'h80);
    dwell(4'hF, 8'hFF, 4);
    drain("mid_rst_drain");
    tick(10);
    chk("final_queue_empty", 32'(sb_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
